pmem_responder: RTL and testbench

//  Memory-side responder for the LSU load/store request protocol. Accepts one request
//  at a time (addr, write enable, 64-bit data, low-justified byte mask) over a

---
 rtl/pmem_pkg.sv | 34 +++
 rtl/pmem_sram.sv | 33 +++
 rtl/pmem_responder.sv | 151 +++++++++++++++
 tb/tb_pmem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_pkg
//  Purpose  : Shared types, byte-mask constants and the mask expand helper
//             used by the pmem responder and its SRAM array.
//  Revision : 1.0  initial release
// ============================================================================
package pmem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Legal low-justified byte masks: byte, half, word, double
  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  // Widen an 8-bit byte mask into a 64-bit bit mask (one 0xFF lane per set bit)
  function automatic logic [63:0] expand_mask(input logic [7:0] mask);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{mask[i]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pmem_sram.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_sram
//  Purpose  : DEPTH x 64-bit word array. One read/write port, per-byte write
//             enable, combinational read, contents never reset.
//  Revision : 1.0  initial release
// ============================================================================
module pmem_sram #(
  parameter int  DEPTH = 4096,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    be,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] r_mem [DEPTH];

  // Byte-lane writes; lanes with be clear keep their old contents
  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (be[b]) begin
        r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/pmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_responder
//  Purpose  : Memory-side responder for the LSU request protocol. Accepts one
//             request, applies it to the on-chip array after LATENCY cycles and
//             returns load data or error status on the response channel.
//  Revision : 1.0  initial release
// ============================================================================
module pmem_responder
  import pmem_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [3:0]  c_cnt_init = 4'(LATENCY - 1);
  localparam logic [63:0] c_span     = 64'(DEPTH) << 3;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_accept;
  logic          w_access;

  logic [3:0]    r_cnt;
  logic [63:0]   r_addr;
  logic          r_wen;
  logic [63:0]   r_wdata;
  logic [7:0]    r_mask;
  logic [63:0]   r_rdata;
  logic          r_err;

  logic [63:0]   w_off;
  logic [2:0]    w_bytesel;
  logic [5:0]    w_shamt;
  logic [15:0]   w_emask;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [7:0]    w_be;
  logic [63:0]   w_wdata_aligned;
  logic [63:0]   w_sram_rdata;
  logic [63:0]   w_load_data;

  // Address decode works only on the latched request, never on live inputs
  assign w_off     = r_addr - BASE_ADDR;
  assign w_bytesel = w_off[2:0];
  assign w_shamt   = {w_bytesel, 3'b000};
  assign w_emask   = {8'h00, r_mask} << w_bytesel;
  assign w_idx     = w_off[3 +: AW];
  // Below base, beyond the array, or spilling into the next 8-byte word
  assign w_err     = (r_addr < BASE_ADDR) || (w_off >= c_span) || (w_emask[15:8] != 8'h00);

  assign w_wdata_aligned = r_wdata << w_shamt;
  assign w_be            = (w_access && r_wen && !w_err) ? w_emask[7:0] : 8'h00;
  assign w_load_data     = (w_sram_rdata >> w_shamt) & expand_mask(r_mask);

  pmem_sram #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk   (clk),
    .addr  (w_idx),
    .be    (w_be),
    .wdata (w_wdata_aligned),
    .rdata (w_sram_rdata)
  );

  // req_ready is forced low while reset is held, even though the FSM sits in IDLE
  assign req_ready = rst_n && (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and control strobes
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_access     = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid && req_ready) begin
          w_accept     = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access     = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Request latch, latency countdown and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_addr  <= 64'd0;
      r_wen   <= 1'b0;
      r_wdata <= 64'd0;
      r_mask  <= 8'h00;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wen   <= req_wen;
        r_wdata <= req_wdata;
        r_mask  <= req_wmask;
        r_cnt   <= c_cnt_init;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_wen) ? 64'd0 : w_load_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmem_responder
//  Purpose  : Directed self-checking bench for pmem_responder. Three instances
//             with LATENCY 2, 1 and 15 share clock and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pmem_responder;
  import pmem_pkg::*;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       req_valid, req_wen, rsp_ready;
  logic [2:0]       req_ready, rsp_valid, rsp_err;
  logic [2:0][63:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0][7:0]  req_wmask;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] rd;
  logic        er;
  int          lat;
  int          n;

  always #5 clk = ~clk;

  pmem_responder #(.BASE_ADDR(BASE), .DEPTH(4096), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_wen(req_wen[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]));

  pmem_responder #(.BASE_ADDR(BASE), .DEPTH(4096), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_wen(req_wen[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]));

  pmem_responder #(.BASE_ADDR(BASE), .DEPTH(4096), .LATENCY(15)) u_dut_l15 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
    .req_wen(req_wen[2]), .req_wdata(req_wdata[2]), .req_wmask(req_wmask[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // One full transaction with rsp_ready held high; lat = edges from accept to rsp_valid
  task automatic xact(input logic [1:0] sel, input logic [63:0] a, input logic w,
                      input logic [63:0] d, input logic [7:0] m,
                      output logic [63:0] rdo, output logic ero, output int lato);
    int k;
    k = 0;
    @(negedge clk);
    while (req_ready[sel] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_wait", 64'(k < 40), 64'd1);
    req_valid[sel] = 1'b1;
    req_addr[sel]  = a;
    req_wen[sel]   = w;
    req_wdata[sel] = d;
    req_wmask[sel] = m;
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    lato = 0;
    while (rsp_valid[sel] !== 1'b1 && lato < 40) begin
      @(posedge clk); #1;
      lato++;
    end
    rdo = rsp_rdata[sel];
    ero = rsp_err[sel];
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_wen   = '0;
    rsp_ready = '1;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;

    // Reset state
    #12;
    chk("rst_req_ready", 64'(req_ready[0]), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata[0], 64'd0);
    chk("rst_rsp_err",   64'(rsp_err[0]), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_req_ready", 64'(req_ready[0]), 64'd1);
    chk("rel_rsp_valid", 64'(rsp_valid[0]), 64'd0);

    // Full-word store then load
    xact(2'd0, BASE, 1'b1, 64'h1122334455667788, MASK_D, rd, er, lat);
    chk("st_d_lat", 64'(lat), 64'd2);
    chk("st_d_err", 64'(er), 64'd0);
    chk("st_d_rdata", rd, 64'd0);
    xact(2'd0, BASE, 1'b0, 64'd0, MASK_D, rd, er, lat);
    chk("ld_d_lat", 64'(lat), 64'd2);
    chk("ld_d_rdata", rd, 64'h1122334455667788);
    chk("ld_d_err", 64'(er), 64'd0);

    // Reset asserted mid-WAIT drops the pending store
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = BASE; req_wen[0] = 1'b1;
    req_wdata[0] = 64'hDEADBEEFCAFEF00D; req_wmask[0] = MASK_D;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("wait_req_ready", 64'(req_ready[0]), 64'd0);
    #1 rst_n = 1'b0; #1;
    chk("wrst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("wrst_req_ready", 64'(req_ready[0]), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("wrst_rel_ready", 64'(req_ready[0]), 64'd1);
    xact(2'd0, BASE, 1'b0, 64'd0, MASK_D, rd, er, lat);
    chk("wrst_dropped", rd, 64'h1122334455667788);

    // Byte store into lane 5, then several load widths
    xact(2'd0, BASE + 64'd5, 1'b1, 64'h00000000000000AB, MASK_B, rd, er, lat);
    chk("st_b_err", 64'(er), 64'd0);
    xact(2'd0, BASE, 1'b0, 64'd0, MASK_D, rd, er, lat);
    chk("ld_merge", rd, 64'h1122AB4455667788);
    xact(2'd0, BASE + 64'd5, 1'b0, 64'd0, MASK_B, rd, er, lat);
    chk("ld_b5", rd, 64'h00000000000000AB);
    xact(2'd0, BASE + 64'd2, 1'b0, 64'd0, MASK_H, rd, er, lat);
    chk("ld_h2", rd, 64'h0000000000005566);
    xact(2'd0, BASE + 64'd4, 1'b0, 64'd0, MASK_W, rd, er, lat);
    chk("ld_w4", rd, 64'h000000001122AB44);
    xact(2'd0, BASE + 64'd3, 1'b0, 64'd0, 8'h00, rd, er, lat);
    chk("ld_m0_rdata", rd, 64'd0);
    chk("ld_m0_err", 64'(er), 64'd0);

    // Error cases
    xact(2'd0, BASE + 64'd6, 1'b0, 64'd0, MASK_W, rd, er, lat);
    chk("mis_ld_err", 64'(er), 64'd1);
    chk("mis_ld_rdata", rd, 64'd0);
    xact(2'd0, BASE + 64'd6, 1'b1, 64'hFFFFFFFFFFFFFFFF, MASK_W, rd, er, lat);
    chk("mis_st_err", 64'(er), 64'd1);
    xact(2'd0, BASE, 1'b0, 64'd0, MASK_D, rd, er, lat);
    chk("mis_st_nowrite", rd, 64'h1122AB4455667788);
    xact(2'd0, 64'h7FFF_FFF8, 1'b0, 64'd0, MASK_D, rd, er, lat);
    chk("below_err", 64'(er), 64'd1);
    xact(2'd0, BASE + 64'd32768, 1'b0, 64'd0, MASK_D, rd, er, lat);
    chk("above_err", 64'(er), 64'd1);
    chk("above_rdata", rd, 64'd0);
    xact(2'd0, BASE + 64'd32760, 1'b1, 64'h5A5A5A5AA5A5A5A5, MASK_D, rd, er, lat);
    chk("top_st_err", 64'(er), 64'd0);
    xact(2'd0, BASE + 64'd32760, 1'b0, 64'd0, MASK_D, rd, er, lat);
    chk("top_ld", rd, 64'h5A5A5A5AA5A5A5A5);
    xact(2'd0, BASE, 1'b0, 64'd0, MASK_D, rd, er, lat);
    chk("top_no_alias", rd, 64'h1122AB4455667788);

    // Backpressure in RESP with ignored request pulses
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = BASE; req_wen[0] = 1'b0; req_wmask[0] = MASK_D;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_lat", 64'(n), 64'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = BASE;
      req_wdata[0] = 64'(i); req_wmask[0] = MASK_D;
      @(posedge clk); #1;
      chk("bp_valid", 64'(rsp_valid[0]), 64'd1);
      chk("bp_rdata", rsp_rdata[0], 64'h1122AB4455667788);
      chk("bp_err", 64'(rsp_err[0]), 64'd0);
      chk("bp_req_ready", 64'(req_ready[0]), 64'd0);
    end
    @(negedge clk); rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("bp_rel_valid", 64'(rsp_valid[0]), 64'd0);
    chk("bp_rel_ready", 64'(req_ready[0]), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_not_accepted", 64'(rsp_valid[0]), 64'd0);
    xact(2'd0, BASE, 1'b0, 64'd0, MASK_D, rd, er, lat);
    chk("bp_mem_intact", rd, 64'h1122AB4455667788);

    // Reset asserted in RESP clears outputs asynchronously
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = BASE; req_wen[0] = 1'b0; req_wmask[0] = MASK_D;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rrst_pre_rdata", rsp_rdata[0], 64'h1122AB4455667788);
    #1 rst_n = 1'b0; #1;
    chk("rrst_valid", 64'(rsp_valid[0]), 64'd0);
    chk("rrst_rdata", rsp_rdata[0], 64'd0);
    chk("rrst_err", 64'(rsp_err[0]), 64'd0);
    rsp_ready[0] = 1'b1;
    @(negedge clk); rst_n = 1'b1;

    // Latency sweep: back-to-back transactions on LATENCY=1 and LATENCY=15
    for (int s = 1; s <= 2; s++) begin
      int exp_lat;
      exp_lat = (s == 1) ? 1 : 15;
      xact(2'(s), BASE + 64'd8, 1'b1, 64'h0123456789ABCDEF, MASK_D, rd, er, lat);
      chk("sw_st_lat", 64'(lat), 64'(exp_lat));
      xact(2'(s), BASE + 64'd8, 1'b0, 64'd0, MASK_D, rd, er, lat);
      chk("sw_ld_lat", 64'(lat), 64'(exp_lat));
      chk("sw_ld_rdata", rd, 64'h0123456789ABCDEF);
      xact(2'(s), BASE + 64'd8, 1'b0, 64'd0, MASK_H, rd, er, lat);
      chk("sw_ldh_lat", 64'(lat), 64'(exp_lat));
      chk("sw_ldh_rdata", rd, 64'h000000000000CDEF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
